cond_branch_seq: RTL and testbench
==================================

Name: cond_branch_seq

Overview:
Instruction sequencer for the 8-bit model computer. It fetches 4-byte instructions (OPCODE, ARG1, ARG2, DEST) from byte-wide program memory over a req/ack handshake. Compare-and-branch instructions (OPCODE[5]=1) are evaluated through the external COND unit, and PC is redirected when the result is true. All other instructions are issued to the execute stage and held until it finishes.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset
REG_AW, 3, register-file read address width

Ports:
CLK  in  1  clock; all state updates on rising edge
RST_N  in  1  reset, synchronous, active-low
HALT  in  1  when high, no new instruction fetch starts (sampled at instruction boundary only)
MEM_REQ  out  1  program-memory read request
MEM_ADDR  out  8  program-memory byte address
MEM_ACK  in  1  memory data valid this cycle
MEM_DATA  in  8  fetched byte
REG_RADDR  out  REG_AW  register-file read address (combinational read)
REG_RDATA  in  8  register-file read data
COND_CODE  out  8  to COND CONDITION input
COND_A  out  8  to COND INPUT1
COND_B  out  8  to COND INPUT2
COND_RESULT  in  1  from COND OUTPUT
PC  out  8  current instruction address
INSTR_VALID  out  1  non-branch instruction presented to execute stage
OPCODE, ARG1, ARG2, DEST  out  8 each  latched instruction bytes
EXEC_DONE  in  1  execute stage accepts/completes issued instruction

Behaviour:
- Reset (RST_N=0 at an edge) forces the following, regardless of state:
  - PC=RESET_PC, state=FETCH, byte index=0.
  - All other outputs 0; COND_CODE=8'h00.
  - An in-flight fetch is abandoned. An ACK arriving after reset belongs to no request and is ignored.
- States: FETCH, OP_A, OP_B, EVAL, ISSUE.
- FETCH:
  - When idx=0 and HALT=1: MEM_REQ=0 and the block stays in FETCH.
  - Otherwise MEM_REQ=1 and MEM_ADDR=PC+idx (mod 256).
  - MEM_ADDR and MEM_REQ are held stable until MEM_ACK=1.
  - On the ACK edge, MEM_DATA is captured into byte[idx] and idx increments.
  - After byte 3 is captured: if OPCODE[5]=1 go to OP_A, else go to ISSUE.
- OP_A (one cycle):
  - If OPCODE[7]=1, operand A = ARG1 (immediate).
  - Else REG_RADDR=ARG1[REG_AW-1:0] and operand A = REG_RDATA, latched.
- OP_B (one cycle): same rule using OPCODE[6] and ARG2. Both operand cycles are taken even for immediates (fixed latency).
- EVAL (one cycle):
  - COND_CODE=OPCODE, COND_A/COND_B = latched operands. Outside EVAL, COND_CODE=8'h00 and COND_A/COND_B=0.
  - At the end of EVAL: if COND_RESULT=1 then PC<=DEST, else PC<=PC+4 (mod 256). Then go to FETCH.
  - Unsupported codes (OPCODE[4:0]>5) yield COND_RESULT=0 and are treated as not taken; no special case.
- ISSUE:
  - INSTR_VALID=1; OPCODE/ARG1/ARG2/DEST stable.
  - On the first edge with EXEC_DONE=1: PC<=PC+4 (mod 256), INSTR_VALID drops, go to FETCH.
  - EXEC_DONE outside ISSUE is ignored.
- Latency with MEM_ACK tied high:
  - Branch instruction: 7 cycles from first MEM_REQ to PC update.
  - Non-branch: 4 fetch cycles, then ISSUE.
- Each MEM_ACK=0 cycle extends FETCH by one cycle.
- OPCODE..DEST registers update only on their own fetch ACK, and hold through EVAL/ISSUE.
- PC and address arithmetic are 8-bit modulo; there is no overflow flag.

Decomposition:
- Package cond_pkg holds:
  - Condition codes EQ=0, NE=1, LT=2, LE=3, GT=4, GE=5.
  - Bit indices COND_EN=5, IMM2=6, IMM1=7.
  - INSTR_BYTES=4.
  - State enum.
- One sub-module, instr_fetch: byte counter, req/ack handshake and byte assembly; it reports fetch-complete to the top FSM.
- COND stays external and is instanced beside this block.

Test Plan:
1. Hold RST_N=0 for 2 cycles with MEM_ACK=1 -> PC=00, MEM_REQ=0, INSTR_VALID=0, COND_CODE=00. Release reset -> MEM_REQ=1, MEM_ADDR=00 on the next cycle.
2. Memory [E0,05,05,40], MEM_ACK=1, COND model attached -> during EVAL: COND_CODE=E0, COND_A=05, COND_B=05, COND_RESULT=1. PC=40 seven cycles after the first request.
3. Memory [22,01,02,80], R1=09, R2=03 -> REG_RADDR=1 in OP_A and 2 in OP_B; COND_A=09, COND_B=03, result 0 -> PC=04.
4. Memory [00,11,22,33], EXEC_DONE held low 3 cycles in ISSUE -> INSTR_VALID=1 with bytes 00/11/22/33 for 4 cycles; PC=04 after the EXEC_DONE edge.
5. MEM_ACK low for 2 cycles while idx=1 -> MEM_ADDR holds 01 with MEM_REQ=1; instruction completes 2 cycles late with correct bytes.
6. PC=FC, non-branch at FC..FF -> addresses FC,FD,FE,FF, next PC=00. Separately, RST_N=0 mid-fetch with idx=2 -> next cycle PC=RESET_PC, idx=0, no INSTR_VALID.

Source files
------------

// File: rtl/cond_branch_seq_pkg.sv
// Shared constants for the compare-and-branch sequencer: condition codes,
// instruction-byte bit positions and the sequencer state encoding.
package cond_pkg;

  localparam int INSTR_BYTES = 4;

  localparam int COND_EN = 5;
  localparam int IMM2    = 6;
  localparam int IMM1    = 7;

  typedef enum logic [4:0] {
    EQ = 5'd0,
    NE = 5'd1,
    LT = 5'd2,
    LE = 5'd3,
    GT = 5'd4,
    GE = 5'd5
  } cond_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_OP_A,
    S_OP_B,
    S_EVAL,
    S_ISSUE
  } state_e;

endpackage

// File: rtl/cond_branch_seq_if.sv
// Sequencer-side bundle: program memory, register-file read port, COND unit,
// and the execute-stage issue interface.
interface cond_branch_seq_if #(
  parameter int REG_AW = 3
) ();

  logic              halt;
  logic              mem_req;
  logic [7:0]        mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic [REG_AW-1:0] reg_raddr;
  logic [7:0]        reg_rdata;
  logic [7:0]        cond_code;
  logic [7:0]        cond_a;
  logic [7:0]        cond_b;
  logic              cond_result;
  logic [7:0]        pc;
  logic              instr_valid;
  logic [7:0]        opcode;
  logic [7:0]        arg1;
  logic [7:0]        arg2;
  logic [7:0]        dest;
  logic              exec_done;

  modport master (
    input  halt, mem_ack, mem_data, reg_rdata, cond_result, exec_done,
    output mem_req, mem_addr, reg_raddr, cond_code, cond_a, cond_b,
           pc, instr_valid, opcode, arg1, arg2, dest
  );

  modport slave (
    output halt, mem_ack, mem_data, reg_rdata, cond_result, exec_done,
    input  mem_req, mem_addr, reg_raddr, cond_code, cond_a, cond_b,
           pc, instr_valid, opcode, arg1, arg2, dest
  );

endinterface

// File: rtl/cond_branch_seq_fetch.sv
// Byte-wide instruction fetch: walks PC..PC+3 over the req/ack handshake,
// assembles the four instruction bytes and flags the final capture.
module instr_fetch
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active,
  input  logic       halt,
  input  logic [7:0] pc,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  output logic [7:0] opcode,
  output logic [7:0] arg1,
  output logic [7:0] arg2,
  output logic [7:0] dest,
  output logic       done
);

  logic [1:0] idx;
  logic       take;

  // halt only blocks the start of a new instruction, never a partial fetch
  assign mem_req  = rst_n && active && !((idx == 2'd0) && halt);
  assign mem_addr = mem_req ? (pc + {6'd0, idx}) : 8'h00;
  assign take     = mem_req && mem_ack;
  assign done     = take && (idx == 2'(INSTR_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= 2'd0;
      opcode <= 8'h00;
      arg1   <= 8'h00;
      arg2   <= 8'h00;
      dest   <= 8'h00;
    end else if (take) begin
      idx <= idx + 2'd1;
      unique case (idx)
        2'd0: opcode <= mem_data;
        2'd1: arg1   <= mem_data;
        2'd2: arg2   <= mem_data;
        2'd3: dest   <= mem_data;
      endcase
    end
  end

endmodule

// File: rtl/cond_branch_seq.sv
// Instruction sequencer: fetch, then either evaluate a compare-and-branch
// through the external COND unit or issue to execute and wait for done.
//
// state   | meaning
// S_FETCH | fetching 4 instruction bytes (idle while halted at byte 0)
// S_OP_A  | latch operand A (immediate ARG1 or register read)
// S_OP_B  | latch operand B (immediate ARG2 or register read)
// S_EVAL  | present operands to COND, redirect or step PC
// S_ISSUE | hold instruction for execute stage until exec_done
module cond_branch_seq
  import cond_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         REG_AW   = 3
) (
  input logic              clk,
  input logic              rst_n,
  cond_branch_seq_if.master bus
);

  state_e            state, state_nxt;
  logic [7:0]        pc, pc_nxt;
  logic [7:0]        opnd_a, opnd_b, opnd_sel;
  logic [REG_AW-1:0] raddr;
  logic [7:0]        opcode, arg1, arg2, dest;
  logic              fetch_done;
  logic              in_eval;

  instr_fetch u_fetch (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (state == S_FETCH),
    .halt     (bus.halt),
    .pc       (pc),
    .mem_ack  (bus.mem_ack),
    .mem_data (bus.mem_data),
    .mem_req  (bus.mem_req),
    .mem_addr (bus.mem_addr),
    .opcode   (opcode),
    .arg1     (arg1),
    .arg2     (arg2),
    .dest     (dest),
    .done     (fetch_done)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    raddr     = '0;
    opnd_sel  = 8'h00;
    unique case (state)
      S_FETCH: begin
        if (fetch_done) state_nxt = opcode[COND_EN] ? S_OP_A : S_ISSUE;
      end
      S_OP_A: begin
        if (!opcode[IMM1]) raddr = arg1[REG_AW-1:0];
        opnd_sel  = opcode[IMM1] ? arg1 : bus.reg_rdata;
        state_nxt = S_OP_B;
      end
      S_OP_B: begin
        if (!opcode[IMM2]) raddr = arg2[REG_AW-1:0];
        opnd_sel  = opcode[IMM2] ? arg2 : bus.reg_rdata;
        state_nxt = S_EVAL;
      end
      S_EVAL: begin
        pc_nxt    = bus.cond_result ? dest : (pc + 8'd4);
        state_nxt = S_FETCH;
      end
      S_ISSUE: begin
        if (bus.exec_done) begin
          pc_nxt    = pc + 8'd4;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      opnd_a <= 8'h00;
      opnd_b <= 8'h00;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == S_OP_A) opnd_a <= opnd_sel;
      if (state == S_OP_B) opnd_b <= opnd_sel;
    end
  end

  // outputs are forced quiet while reset is asserted, whatever the state
  assign in_eval         = rst_n && (state == S_EVAL);
  assign bus.cond_code   = in_eval ? opcode : 8'h00;
  assign bus.cond_a      = in_eval ? opnd_a : 8'h00;
  assign bus.cond_b      = in_eval ? opnd_b : 8'h00;
  assign bus.reg_raddr   = rst_n ? raddr : '0;
  assign bus.instr_valid = rst_n && (state == S_ISSUE);
  assign bus.pc          = pc;
  assign bus.opcode      = opcode;
  assign bus.arg1        = arg1;
  assign bus.arg2        = arg2;
  assign bus.dest        = dest;

endmodule

// File: tb/tb_cond_branch_seq.sv
// Bench for cond_branch_seq: program memory, register file and COND model,
// an instruction-level scoreboard, and directed literal checks.
module tb_cond_branch_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cond_branch_seq_if #(.REG_AW(3)) bus ();

  cond_branch_seq #(.RESET_PC(8'h00), .REG_AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  logic [7:0] rf  [8];
  int         total = 0;
  int         bad   = 0;
  logic       chk_en = 1'b0;
  logic [7:0] exp_pc = 8'h00;
  int         nacks  = 0;
  int         vcnt;

  function automatic logic cond_fn(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c[4:0])
      5'd0:    return a == b;
      5'd1:    return a != b;
      5'd2:    return a <  b;
      5'd3:    return a <= b;
      5'd4:    return a >  b;
      5'd5:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  assign bus.mem_data    = bus.mem_ack ? mem[bus.mem_addr] : 8'hA5;
  assign bus.reg_rdata   = rf[bus.reg_raddr];
  assign bus.cond_result = cond_fn(bus.cond_code, bus.cond_a, bus.cond_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction-level model: PC advances per completed instruction, fetch
  // addresses are PC plus bytes already accepted, and whatever is presented
  // must be the memory contents at the model PC.
  always @(negedge clk) begin : sb
    logic [7:0] a1, a2, a3, b0, b1, b2, b3, ea, eb;
    logic       tk;
    if (chk_en) begin
      a1 = exp_pc + 8'd1;
      a2 = exp_pc + 8'd2;
      a3 = exp_pc + 8'd3;
      b0 = mem[exp_pc];
      b1 = mem[a1];
      b2 = mem[a2];
      b3 = mem[a3];
      ea = b0[7] ? b1 : rf[b1[2:0]];
      eb = b0[6] ? b2 : rf[b2[2:0]];
      tk = cond_fn(b0, ea, eb);
      chk("sb_pc", 32'(bus.pc), 32'(exp_pc));
      if (!rst_n) begin
        chk("sb_rst_quiet", 32'({bus.mem_req, bus.instr_valid, bus.cond_code}), 32'd0);
      end else begin
        if (bus.mem_req)
          chk("sb_addr", 32'({nacks < 4, bus.mem_addr}), 32'({1'b1, 8'(exp_pc + 8'(nacks))}));
        if (bus.instr_valid) begin
          chk("sb_issue", {bus.opcode, bus.arg1, bus.arg2, bus.dest}, {b0, b1, b2, b3});
          chk("sb_issue_kind", 32'({b0[5], nacks == 4}), 32'b01);
        end
        if (bus.cond_code != 8'h00) begin
          chk("sb_eval", 32'({bus.cond_code, bus.cond_a, bus.cond_b}), 32'({b0, ea, eb}));
          chk("sb_eval_cnt", 32'(nacks), 32'd4);
        end
      end
      if (!rst_n) begin
        exp_pc = 8'h00;
        nacks  = 0;
      end else if (bus.instr_valid && bus.exec_done) begin
        exp_pc = exp_pc + 8'd4;
        nacks  = 0;
      end else if (bus.cond_code != 8'h00) begin
        exp_pc = tk ? b3 : (exp_pc + 8'd4);
        nacks  = 0;
      end else if (bus.mem_req && bus.mem_ack) begin
        nacks++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    {mem[8'h00], mem[8'h01], mem[8'h02], mem[8'h03]} = {8'hE0, 8'h05, 8'h05, 8'h40};
    {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} = {8'h22, 8'h01, 8'h02, 8'h80};
    {mem[8'h44], mem[8'h45], mem[8'h46], mem[8'h47]} = {8'h00, 8'h11, 8'h22, 8'h33};
    {mem[8'h48], mem[8'h49], mem[8'h4A], mem[8'h4B]} = {8'h01, 8'h02, 8'h03, 8'h04};
    {mem[8'h4C], mem[8'h4D], mem[8'h4E], mem[8'h4F]} = {8'hA0, 8'h00, 8'h07, 8'hFC};
    {mem[8'hFC], mem[8'hFD], mem[8'hFE], mem[8'hFF]} = {8'h10, 8'h9A, 8'hBC, 8'hDE};
    rf[0] = 8'h55;
    rf[1] = 8'h09;
    rf[2] = 8'h03;
    rf[7] = 8'h00;

    rst_n         = 1'b0;
    bus.halt      = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.exec_done = 1'b0;

    // reset held two edges with ack high
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'({bus.pc, bus.mem_req, bus.instr_valid, bus.cond_code}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", 32'({bus.mem_req, bus.mem_addr}), 32'h100);

    // immediate EQ branch, taken to 40
    repeat (6) @(negedge clk);
    chk("br_imm_eval", 32'({bus.cond_code, bus.cond_a, bus.cond_b}), 32'hE00505);
    chk("br_imm_result", 32'(bus.cond_result), 32'd1);
    @(posedge clk); #1;
    bus.halt = 1'b1;
    @(negedge clk);
    chk("br_taken_pc", 32'({bus.pc, bus.mem_req}), 32'({8'h40, 1'b0}));

    // register LT branch, not taken
    @(posedge clk); #1;
    bus.halt = 1'b0;
    repeat (5) @(negedge clk);
    chk("op_a_raddr", 32'(bus.reg_raddr), 32'd1);
    @(negedge clk);
    chk("op_b_raddr", 32'(bus.reg_raddr), 32'd2);
    @(negedge clk);
    chk("br_reg_eval", 32'({bus.cond_code, bus.cond_a, bus.cond_b, bus.cond_result}),
        32'({8'h22, 8'h09, 8'h03, 1'b0}));
    @(posedge clk); #1;
    bus.halt = 1'b1;
    @(negedge clk);
    chk("br_not_taken_pc", 32'(bus.pc), 32'h44);

    // non-branch issue, exec_done delayed three cycles; halt mid-fetch ignored
    @(posedge clk); #1;
    bus.halt = 1'b0;
    @(posedge clk); #1;
    bus.halt = 1'b1;
    @(negedge clk);
    chk("halt_midfetch", 32'({bus.mem_req, bus.mem_addr}), 32'h145);
    repeat (3) @(posedge clk);
    #1;
    vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.instr_valid) vcnt++;
      chk("issue_bytes", {bus.opcode, bus.arg1, bus.arg2, bus.dest}, 32'h00112233);
      @(posedge clk); #1;
    end
    bus.exec_done = 1'b1;
    @(negedge clk);
    if (bus.instr_valid) vcnt++;
    chk("issue_cycles", 32'(vcnt), 32'd4);
    @(posedge clk); #1;
    bus.exec_done = 1'b0;
    @(negedge clk);
    chk("issue_done_pc", 32'({bus.pc, bus.instr_valid}), 32'({8'h48, 1'b0}));

    // ack stalls two cycles on byte 1
    @(posedge clk); #1;
    bus.halt = 1'b0;
    @(posedge clk); #1;
    bus.halt    = 1'b1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("stall_hold1", 32'({bus.mem_req, bus.mem_addr}), 32'h149);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_hold2", 32'({bus.mem_req, bus.mem_addr}), 32'h149);
    @(posedge clk); #1;
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_not_yet", 32'(bus.instr_valid), 32'd0);
    @(posedge clk); #1;
    bus.exec_done = 1'b1;
    @(negedge clk);
    chk("stall_bytes", 32'({bus.instr_valid, bus.opcode, bus.arg1, bus.arg2}),
        32'({1'b1, 8'h01, 8'h02, 8'h03}));
    chk("stall_dest", 32'(bus.dest), 32'h04);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_pc", 32'(bus.pc), 32'h4C);

    // mixed immediate/register branch to FC, then non-branch wrapping to 00
    @(posedge clk); #1;
    bus.halt = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrap_addr", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, 8'(8'hFC + 8'(i))}));
      @(posedge clk); #1;
      if (i == 0) bus.halt = 1'b1;
    end
    @(negedge clk);
    chk("wrap_issue", 32'({bus.instr_valid, bus.opcode}), 32'({1'b1, 8'h10}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap_pc", 32'({bus.pc, bus.mem_req}), 32'({8'h00, 1'b0}));

    // reset during fetch of byte 2 at PC 40
    @(posedge clk); #1;
    bus.halt = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_before", 32'({bus.pc, bus.mem_req}), 32'({8'h40, 1'b0}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_fetch", 32'({bus.pc, bus.mem_req, bus.mem_addr, bus.instr_valid}),
        32'({8'h00, 1'b1, 8'h00, 1'b0}));
    chk("midrst_bytes", {bus.opcode, bus.arg1, bus.arg2, bus.dest}, 32'd0);

    // free run through the whole program under the scoreboard
    repeat (40) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
